uoram_client_adapter: RTL and testbench
=======================================

# uoram_client_adapter

Network-side initiator for the unified ORAM frontend: accepts whole-block requests (command, program address, write mask, block data) from a client such as the LLC and drives the frontend's command, write-data and return-data channels. Serializes write blocks into FEDWidth chunks and reassembles returned chunks into a block. Performs the address range check on its own side so an out-of-range request never reaches the frontend.

## Interface
Parameters:
- ORAMB, 512, block size in bits
- FEDWidth, 64, frontend data chunk width; Chunks = ceil(ORAMB/FEDWidth) (8 at defaults)
- ORAMU, 32, program address width
- NumValidBlock, 1024, first invalid program address
- BECMDWidth, 2, command width (BECMD_Update/Read/ReadRmv/Append from the shared command header)
- DMWidth, Chunks, write-mask width (one bit per chunk)

Ports:
- Clock  in  1  sole clock
- Reset  in  1  asynchronous, active-low reset
- ReqReady  out  1  adapter can accept a request
- ReqValid  in  1  client request valid
- ReqCmd  in  BECMDWidth  command
- ReqAddr  in  ORAMU  program block address
- ReqMask  in  DMWidth  write mask, forwarded unchanged
- ReqData  in  ORAMB  write block, ignored for Read/ReadRmv
- RespReady  in  1  client accepts response
- RespValid  out  1  read response valid
- RespData  out  ORAMB  read block
- RespError  out  1  response belongs to an out-of-range request
- CmdOutReady  in  1  frontend accepts command
- CmdOutValid  out  1  command valid
- CmdOut  out  BECMDWidth  command to frontend
- ProgAddrOut  out  ORAMU  address to frontend
- WMaskOut  out  DMWidth  mask to frontend
- DataOutReady  in  1  frontend accepts data chunk
- DataOutValid  out  1  data chunk valid
- DataOut  out  FEDWidth  data chunk
- ReturnDataReady  out  1  adapter accepts return chunk
- ReturnDataValid  in  1  return chunk valid
- ReturnData  in  FEDWidth  return chunk
- ErrorOutOfRange  out  1  sticky: some request had ReqAddr >= NumValidBlock

## Operation
- States: IDLE, CMD, DATA, WAIT, RESP. One request in flight.
- IDLE: ReqReady=1. On ReqValid: latch Cmd/Addr/Mask/Data.
  - ReqAddr >= NumValidBlock: set ErrorOutOfRange; Read/ReadRmv -> RESP with RespData=0, RespError=1; Update/Append -> IDLE (dropped silently). Nothing sent to frontend.
  - Otherwise -> CMD.
- CMD: CmdOutValid=1 with latched fields. On CmdOutReady: Update/Append -> DATA; Read/ReadRmv -> WAIT.
- DATA: DataOut = latched block chunk[Cnt] (chunk 0 = bits FEDWidth-1:0). Cnt increments per DataOutValid&&DataOutReady; after chunk Chunks-1 -> IDLE, Cnt=0. Last chunk zero-padded when ORAMB is not a multiple of FEDWidth.
- WAIT: ReturnDataReady=1; each beat written into chunk slot Cnt, Cnt++; after Chunks-th beat -> RESP, Cnt=0, RespError=0.
- RESP: RespValid=1, RespData/RespError stable; on RespReady -> IDLE.
- ReturnDataReady=0 outside WAIT; DataOutValid=0 outside DATA; CmdOutValid=0 outside CMD.
- Cnt width clog2(Chunks)+1; never wraps in normal operation.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state IDLE, Cnt=0, ErrorOutOfRange=0, RespValid=0, CmdOutValid=0, DataOutValid=0, ReturnDataReady=0, RespData=0, RespError=0; ReqReady=1 from the first edge after deassert. Reset mid-transfer abandons the request; no partial beats after reset.
- Request accepted at edge T -> CmdOutValid high in cycle T+1 (registered, no combinational path from ReqValid to CmdOutValid).
- Write: CmdOut handshake at edge C -> chunk 0 valid in C+1; full-rate back-to-back chunks; ReqReady high in the cycle after the last chunk handshake. Minimum write occupancy: 1+1+Chunks cycles.
- Read: last return beat at edge L -> RespValid high in L+1; ReqReady high in the cycle after RespReady handshake.
- Valid held with stable payload until Ready; Ready-before-Valid permitted on all channels.
- Out-of-range read: RespValid in T+1. Out-of-range write: ReqReady high again in T+1.
- ErrorOutOfRange asserts in T+1 and stays high until Reset.

## Test plan
- Write: Update, addr 5, data = chunks 0x00..0x07, DataOutReady always 1 -> CmdOut at T+1, chunks 0x00..0x07 in order on consecutive cycles, ReqReady at T+10.
- Read with backpressure: Read addr 7, frontend returns 0xA0..0xA7 with ReturnDataValid toggling 1/0 -> RespData = {0xA7..0xA0}, RespError=0, RespValid one cycle after 8th beat.
- Stalled handshakes: CmdOutReady low 5 cycles, DataOutReady low on chunk 3 for 4 cycles -> CmdOut/DataOut stable while stalled, no duplicated or skipped chunk.
- Out-of-range: Read addr NumValidBlock -> no CmdOutValid, RespValid at T+1 with data 0 and RespError=1, ErrorOutOfRange=1; subsequent valid Append proceeds normally, error stays 1.
- RespReady held low 10 cycles -> RespValid/RespData stable, ReqReady=0, ReturnDataReady=0 throughout.
- Reset low during chunk 4 of a write -> all outputs to reset values immediately; after release, new Read addr 0 completes with Cnt starting at 0.

Source files
------------

// File: rtl/uoram_client_adapter.sv
// uoram_client_adapter: block-level client front end for the unified ORAM frontend.
// Takes one whole-block request at a time. The request is range-checked locally.
// For an in-range request the adapter issues the command, then serializes a write
// block into FEDWidth chunks, or reassembles a read block from the returned chunks.
module uoram_client_adapter #(
  parameter int ORAMB         = 512,
  parameter int FEDWidth      = 64,
  parameter int ORAMU         = 32,
  parameter int NumValidBlock = 1024,
  parameter int BECMDWidth    = 2,
  parameter int DMWidth       = (ORAMB + FEDWidth - 1) / FEDWidth
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic                  ReqReady,
  input  logic                  ReqValid,
  input  logic [BECMDWidth-1:0] ReqCmd,
  input  logic [ORAMU-1:0]      ReqAddr,
  input  logic [DMWidth-1:0]    ReqMask,
  input  logic [ORAMB-1:0]      ReqData,
  input  logic                  RespReady,
  output logic                  RespValid,
  output logic [ORAMB-1:0]      RespData,
  output logic                  RespError,
  input  logic                  CmdOutReady,
  output logic                  CmdOutValid,
  output logic [BECMDWidth-1:0] CmdOut,
  output logic [ORAMU-1:0]      ProgAddrOut,
  output logic [DMWidth-1:0]    WMaskOut,
  input  logic                  DataOutReady,
  output logic                  DataOutValid,
  output logic [FEDWidth-1:0]   DataOut,
  output logic                  ReturnDataReady,
  input  logic                  ReturnDataValid,
  input  logic [FEDWidth-1:0]   ReturnData,
  output logic                  ErrorOutOfRange
);

  localparam int Chunks = (ORAMB + FEDWidth - 1) / FEDWidth;
  localparam int BW     = Chunks * FEDWidth;
  localparam int CW     = $clog2(Chunks) + 1;

  // Command encodings shared with the frontend
  localparam logic [BECMDWidth-1:0] BECMD_Update  = BECMDWidth'(0);
  localparam logic [BECMDWidth-1:0] BECMD_Append  = BECMDWidth'(1);
  localparam logic [BECMDWidth-1:0] BECMD_Read    = BECMDWidth'(2);
  localparam logic [BECMDWidth-1:0] BECMD_ReadRmv = BECMDWidth'(3);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DATA, ST_WAIT, ST_RESP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BECMDWidth-1:0]   cmd_q, cmd_d;
  logic [ORAMU-1:0]        addr_q, addr_d;
  logic [DMWidth-1:0]      mask_q, mask_d;
  logic [ORAMB-1:0]        blk_q, blk_d;
  logic [BW-1:0]           rbuf_q, rbuf_d;
  logic                    resp_err_q, resp_err_d;
  logic                    oor_q, oor_d;
  logic                    req_ready_q, req_ready_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic                    data_valid_q, data_valid_d;
  logic                    ret_ready_q, ret_ready_d;
  logic                    resp_valid_q, resp_valid_d;

  logic                    req_fire, cmd_fire, data_fire, ret_fire, resp_fire;
  logic                    last_chunk;
  logic [BW-1:0]           blk_padded;
  logic [FEDWidth-1:0]     data_out;

  function automatic logic is_read(input logic [BECMDWidth-1:0] c);
    return (c == BECMD_Read) || (c == BECMD_ReadRmv);
  endfunction

  assign req_fire   = req_ready_q && ReqValid;
  assign cmd_fire   = cmd_valid_q && CmdOutReady;
  assign data_fire  = data_valid_q && DataOutReady;
  assign ret_fire   = ret_ready_q && ReturnDataValid;
  assign resp_fire  = resp_valid_q && RespReady;
  assign last_chunk = (cnt_q == CW'(Chunks - 1));

  // Select the outgoing write chunk; the block is zero-padded to a whole number of chunks
  always_comb begin
    blk_padded            = '0;
    blk_padded[ORAMB-1:0] = blk_q;
    data_out              = '0;
    for (int i = 0; i < Chunks; i++) begin
      if (cnt_q == CW'(i)) data_out = blk_padded[i*FEDWidth +: FEDWidth];
    end
  end

  // Next-state and next-output computation for the request sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    blk_d      = blk_q;
    rbuf_d     = rbuf_q;
    resp_err_d = resp_err_q;
    oor_d      = oor_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          cmd_d  = ReqCmd;
          addr_d = ReqAddr;
          mask_d = ReqMask;
          blk_d  = ReqData;
          if (ReqAddr >= ORAMU'(NumValidBlock)) begin
            // Out-of-range: never reaches the frontend; reads get an error response, writes vanish
            oor_d = 1'b1;
            if (is_read(ReqCmd)) begin
              rbuf_d     = '0;
              resp_err_d = 1'b1;
              state_d    = ST_RESP;
            end
          end else begin
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (cmd_fire) state_d = is_read(cmd_q) ? ST_WAIT : ST_DATA;
      end
      ST_DATA: begin
        if (data_fire) begin
          if (last_chunk) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (ret_fire) begin
          for (int i = 0; i < Chunks; i++) begin
            if (cnt_q == CW'(i)) rbuf_d[i*FEDWidth +: FEDWidth] = ReturnData;
          end
          if (last_chunk) begin
            cnt_d      = '0;
            resp_err_d = 1'b0;
            state_d    = ST_RESP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_RESP: begin
        if (resp_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are registered copies of the next-state decode
    req_ready_d  = (state_d == ST_IDLE);
    cmd_valid_d  = (state_d == ST_CMD);
    data_valid_d = (state_d == ST_DATA);
    ret_ready_d  = (state_d == ST_WAIT);
    resp_valid_d = (state_d == ST_RESP);
  end

  // Single state register; reset abandons any in-flight request
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      mask_q       <= '0;
      blk_q        <= '0;
      rbuf_q       <= '0;
      resp_err_q   <= 1'b0;
      oor_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      ret_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      blk_q        <= blk_d;
      rbuf_q       <= rbuf_d;
      resp_err_q   <= resp_err_d;
      oor_q        <= oor_d;
      req_ready_q  <= req_ready_d;
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      ret_ready_q  <= ret_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign ReqReady        = req_ready_q;
  assign CmdOutValid     = cmd_valid_q;
  assign CmdOut          = cmd_q;
  assign ProgAddrOut     = addr_q;
  assign WMaskOut        = mask_q;
  assign DataOutValid    = data_valid_q;
  assign DataOut         = data_out;
  assign ReturnDataReady = ret_ready_q;
  assign RespValid       = resp_valid_q;
  assign RespData        = rbuf_q[ORAMB-1:0];
  assign RespError       = resp_err_q;
  assign ErrorOutOfRange = oor_q;

endmodule

// File: tb/tb_uoram_client_adapter.sv
// Directed bench for uoram_client_adapter at default parameters.
module tb_uoram_client_adapter;

  localparam logic [1:0] C_UPDATE  = 2'd0;
  localparam logic [1:0] C_APPEND  = 2'd1;
  localparam logic [1:0] C_READ    = 2'd2;
  localparam logic [1:0] C_READRMV = 2'd3;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         ReqReady, ReqValid;
  logic [1:0]   ReqCmd;
  logic [31:0]  ReqAddr;
  logic [7:0]   ReqMask;
  logic [511:0] ReqData;
  logic         RespReady, RespValid, RespError;
  logic [511:0] RespData;
  logic         CmdOutReady, CmdOutValid;
  logic [1:0]   CmdOut;
  logic [31:0]  ProgAddrOut;
  logic [7:0]   WMaskOut;
  logic         DataOutReady, DataOutValid;
  logic [63:0]  DataOut;
  logic         ReturnDataReady, ReturnDataValid;
  logic [63:0]  ReturnData;
  logic         ErrorOutOfRange;

  int n_tests = 0;
  int n_fail  = 0;

  uoram_client_adapter dut (
    .Clock(Clock), .Reset(Reset),
    .ReqReady(ReqReady), .ReqValid(ReqValid), .ReqCmd(ReqCmd), .ReqAddr(ReqAddr),
    .ReqMask(ReqMask), .ReqData(ReqData),
    .RespReady(RespReady), .RespValid(RespValid), .RespData(RespData), .RespError(RespError),
    .CmdOutReady(CmdOutReady), .CmdOutValid(CmdOutValid), .CmdOut(CmdOut),
    .ProgAddrOut(ProgAddrOut), .WMaskOut(WMaskOut),
    .DataOutReady(DataOutReady), .DataOutValid(DataOutValid), .DataOut(DataOut),
    .ReturnDataReady(ReturnDataReady), .ReturnDataValid(ReturnDataValid), .ReturnData(ReturnData),
    .ErrorOutOfRange(ErrorOutOfRange)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Block whose chunk i holds base+i
  function automatic logic [511:0] blk(input logic [7:0] base);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[i*64 +: 64] = {56'd0, base + 8'(i)};
    return b;
  endfunction

  task automatic req(input logic [1:0] c, input logic [31:0] a, input logic [7:0] m, input logic [511:0] d);
    ReqValid = 1'b1; ReqCmd = c; ReqAddr = a; ReqMask = m; ReqData = d;
    step();
    ReqValid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmdv"}, CmdOutValid, 1'b0);
    chk({tag, "_datav"}, DataOutValid, 1'b0);
    chk({tag, "_retr"}, ReturnDataReady, 1'b0);
    chk({tag, "_respv"}, RespValid, 1'b0);
    chk({tag, "_respd"}, RespData, '0);
    chk({tag, "_respe"}, RespError, 1'b0);
    chk({tag, "_oor"}, ErrorOutOfRange, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    ReqValid = 0; ReqCmd = 0; ReqAddr = 0; ReqMask = 0; ReqData = '0;
    RespReady = 0; CmdOutReady = 0; DataOutReady = 0; ReturnDataValid = 0; ReturnData = '0;
    #3 Reset = 1'b0;
    step(); step();
    chk_idle_outputs("rst");
    Reset = 1'b1;
    step();
    chk("rst_reqready", ReqReady, 1'b1);

    // Write: Update addr 5, full-rate chunks
    CmdOutReady = 1; DataOutReady = 1;
    req(C_UPDATE, 32'd5, 8'hA5, blk(8'h00));
    chk("wr_cmdv", CmdOutValid, 1'b1);
    chk("wr_cmd", CmdOut, C_UPDATE);
    chk("wr_addr", ProgAddrOut, 32'd5);
    chk("wr_mask", WMaskOut, 8'hA5);
    chk("wr_reqready_busy", ReqReady, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("wr_datav", DataOutValid, 1'b1);
      chk("wr_chunk", DataOut, 64'(i));
      step();
    end
    chk("wr_reqready_t10", ReqReady, 1'b1);
    chk("wr_datav_end", DataOutValid, 1'b0);

    // Read addr 7 with toggling return valid
    req(C_READ, 32'd7, 8'h00, '0);
    chk("rd_cmdv", CmdOutValid, 1'b1);
    chk("rd_cmd", CmdOut, C_READ);
    chk("rd_addr", ProgAddrOut, 32'd7);
    step();
    chk("rd_retready", ReturnDataReady, 1'b1);
    chk("rd_no_datav", DataOutValid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ReturnDataValid = 1; ReturnData = 64'h0A0 + 64'(i);
      step();
      ReturnDataValid = 0;
      if (i < 7) begin
        chk("rd_respv_early", RespValid, 1'b0);
        step();
      end
    end
    chk("rd_respv", RespValid, 1'b1);
    chk("rd_respdata", RespData, blk(8'hA0));
    chk("rd_resperr", RespError, 1'b0);
    chk("rd_retready_off", ReturnDataReady, 1'b0);
    RespReady = 1;
    step();
    RespReady = 0;
    chk("rd_reqready_after", ReqReady, 1'b1);
    chk("rd_respv_off", RespValid, 1'b0);

    // Stalled command and data handshakes
    CmdOutReady = 0; DataOutReady = 0;
    req(C_APPEND, 32'd9, 8'h0F, blk(8'h10));
    for (int k = 0; k < 5; k++) begin
      chk("st_cmdv", CmdOutValid, 1'b1);
      chk("st_cmd", CmdOut, C_APPEND);
      chk("st_addr", ProgAddrOut, 32'd9);
      step();
    end
    CmdOutReady = 1; DataOutReady = 1;
    step();
    chk("st_cmdv_off", CmdOutValid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("st_chunk_pre", DataOut, 64'h10 + 64'(i));
      step();
    end
    DataOutReady = 0;
    for (int k = 0; k < 4; k++) begin
      chk("st_hold_v", DataOutValid, 1'b1);
      chk("st_hold_d", DataOut, 64'h13);
      step();
    end
    DataOutReady = 1;
    for (int i = 3; i < 8; i++) begin
      chk("st_chunk_post_v", DataOutValid, 1'b1);
      chk("st_chunk_post", DataOut, 64'h10 + 64'(i));
      step();
    end
    chk("st_reqready", ReqReady, 1'b1);
    chk("st_datav_end", DataOutValid, 1'b0);

    // Out-of-range read, then out-of-range write, then valid Append
    req(C_READ, 32'd1024, 8'h00, '0);
    chk("oor_cmdv", CmdOutValid, 1'b0);
    chk("oor_respv", RespValid, 1'b1);
    chk("oor_respd", RespData, '0);
    chk("oor_respe", RespError, 1'b1);
    chk("oor_flag", ErrorOutOfRange, 1'b1);
    RespReady = 1;
    step();
    RespReady = 0;
    chk("oor_reqready", ReqReady, 1'b1);
    req(C_UPDATE, 32'd2000, 8'hFF, blk(8'h50));
    chk("oorw_reqready", ReqReady, 1'b1);
    chk("oorw_cmdv", CmdOutValid, 1'b0);
    chk("oorw_datav", DataOutValid, 1'b0);
    req(C_APPEND, 32'd3, 8'h01, blk(8'h20));
    chk("ap_cmdv", CmdOutValid, 1'b1);
    chk("ap_addr", ProgAddrOut, 32'd3);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("ap_chunk", DataOut, 64'h20 + 64'(i));
      step();
    end
    chk("ap_reqready", ReqReady, 1'b1);
    chk("ap_flag_sticky", ErrorOutOfRange, 1'b1);

    // Response backpressure for 10 cycles
    req(C_READRMV, 32'd11, 8'h00, '0);
    chk("bp_cmd", CmdOut, C_READRMV);
    step();
    ReturnDataValid = 1;
    for (int i = 0; i < 8; i++) begin
      ReturnData = 64'h0B0 + 64'(i);
      step();
    end
    ReturnDataValid = 0;
    for (int k = 0; k < 10; k++) begin
      chk("bp_respv", RespValid, 1'b1);
      chk("bp_respd", RespData, blk(8'hB0));
      chk("bp_respe", RespError, 1'b0);
      chk("bp_reqready", ReqReady, 1'b0);
      chk("bp_retready", ReturnDataReady, 1'b0);
      step();
    end
    RespReady = 1;
    step();
    RespReady = 0;
    chk("bp_reqready_after", ReqReady, 1'b1);

    // Reset during chunk 4 of a write
    req(C_UPDATE, 32'd4, 8'hFF, blk(8'h30));
    step();
    for (int i = 0; i < 4; i++) step();
    chk("mr_chunk4", DataOut, 64'h34);
    chk("mr_chunk4_v", DataOutValid, 1'b1);
    #2 Reset = 1'b0;
    #1;
    chk_idle_outputs("mr_async");
    step(); step();
    chk_idle_outputs("mr_held");
    Reset = 1'b1;
    step();
    chk("mr_reqready", ReqReady, 1'b1);
    chk("mr_datav", DataOutValid, 1'b0);
    req(C_READ, 32'd0, 8'h00, '0);
    chk("mr_rd_cmdv", CmdOutValid, 1'b1);
    chk("mr_rd_addr", ProgAddrOut, 32'd0);
    step();
    ReturnDataValid = 1;
    for (int i = 0; i < 8; i++) begin
      ReturnData = 64'h0C0 + 64'(i);
      step();
    end
    ReturnDataValid = 0;
    chk("mr_rd_respv", RespValid, 1'b1);
    chk("mr_rd_respd", RespData, blk(8'hC0));
    RespReady = 1;
    step();
    RespReady = 0;
    chk("mr_rd_done", ReqReady, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
